ptp_tx_mux: RTL and testbench
=============================

PTP_TX_MUX -- requirements
Module: ptp_tx_mux

Interface
REQ-001 Parameter DATA_DEPTH, default 256, data-FIFO depth per input in 134-bit words (power of 2).
REQ-002 Parameter VALID_DEPTH, default 16, packet-status FIFO depth per input.
REQ-003 Parameter ALF_MARGIN, default 100, free-word margin below which the input's almost-full is asserted.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 parser2mux_data_wr / parser2mux_data / parser2mux_data_valid / parser2mux_data_valid_wr  in  1/134/1/1  forwarded stream from the ingress dispatcher (port A).
REQ-007 mux2parser_data_alf  out  1  port A almost-full.
REQ-008 ptp2mux_data_wr / ptp2mux_data / ptp2mux_data_valid / ptp2mux_data_valid_wr  in  1/134/1/1  locally generated PTP stream (port B).
REQ-009 mux2ptp_data_alf  out  1  port B almost-full.
REQ-010 mux2sw_data_wr / mux2sw_data / mux2sw_data_valid / mux2sw_data_valid_wr  out  1/134/1/1  merged stream to switch core.
REQ-011 sw2mux_data_alf  in  1  downstream almost-full.

Function
REQ-012 Word format: data[133:132] = 01 first, 11 middle, 10 last; data_valid_wr pulses with or after the last word, data_valid = 1 good / 0 drop.
REQ-013 Each port SHALL write every *_data_wr word into its data FIFO and every *_data_valid_wr flag into its status FIFO (store-and-forward).
REQ-014 A port is eligible only when its status FIFO is non-empty (a complete packet is stored).
REQ-015 FSM states IDLE, ARB, XFER, DROP; IDLE->ARB when any port eligible and sw2mux_data_alf==0.
REQ-016 ARB: round-robin at packet granularity; on simultaneous eligibility the port not served last wins; after reset port A has priority.
REQ-017 ARB pops the status flag; flag 1 -> XFER, flag 0 -> DROP.
REQ-018 XFER: one word per cycle to mux2sw_data, ignoring sw2mux_data_alf mid-packet; on the word with [133:132]==10 assert mux2sw_data_valid_wr=1, mux2sw_data_valid=1 in the same cycle, then ->IDLE.
REQ-019 DROP: reads words until the 10 word, no mux2sw_data_wr, then ->IDLE.
REQ-020 Latency: eligible port, idle output, alf low -> first word on mux2sw_data 3 cycles after the status-FIFO write.
REQ-021 *_alf SHALL be registered, asserted when data-FIFO free words < ALF_MARGIN or status FIFO has <=1 free entry.
REQ-022 Write to a full FIFO SHALL be ignored (upstream protocol violation); read of an empty FIFO never occurs.
REQ-023 A word without a leading 01 at packet start in XFER SHALL still be forwarded; framing is the producer's responsibility.
REQ-024 Simultaneous write and read on one FIFO SHALL leave occupancy unchanged.

Reset
REQ-025 rst SHALL empty all FIFOs, set FSM to IDLE, round-robin pointer to port A, all mux2sw_* outputs to 0, both *_alf to 0.
REQ-026 rst mid-packet SHALL discard the partial packet; no valid_wr is emitted for it.

Configuration
REQ-027 PTP_STRICT_PRIO_EN defined: port B always wins ARB when eligible; undefined: round-robin per REQ-016.

Structure
REQ-028 Shared package: word-type constants (FIRST=01, MID=11, LAST=10), 134-bit width constant, FSM state encoding.
REQ-029 One sub-module pkt_sync_fifo (parameterised width/depth, usedw, full, empty, synchronous reset), instantiated four times.

Verification
REQ-030 Single 4-word good packet on A -> 4 words on output, valid_wr+valid=1 on word 4, first word 3 cycles after status write.
REQ-031 Packets on A and B stored same cycle -> output A,B,A,B order for 4 packets each (round-robin build).
REQ-032 Packet on A with valid=0 followed by good packet on B -> only B packet appears.
REQ-033 sw2mux_data_alf=1 with packets queued -> no output start; release -> transfer begins; alf raised mid-packet -> packet completes.
REQ-034 Write 157 words to A with output blocked -> mux2parser_data_alf=1 one cycle after occupancy reaches 157.
REQ-035 rst during XFER word 2 of 6 -> outputs 0 next cycle, FIFOs empty, no valid_wr emitted.

Source files
------------

// File: rtl/ptp_tx_mux_pkg.sv
// Shared definitions for the PTP transmit mux: word-type codes, word width,
// port indices, FSM state encoding and the packet-level arbitration helper.
package ptp_tx_mux_pkg;

  localparam int WORD_W = 134;

  // Word-type codes carried in data[133:132]
  localparam logic [1:0] WT_FIRST = 2'b01;
  localparam logic [1:0] WT_MID   = 2'b11;
  localparam logic [1:0] WT_LAST  = 2'b10;

  localparam int   NUM_PORTS = 2;
  localparam logic PORT_A    = 1'b0;  // forwarded stream from the parser
  localparam logic PORT_B    = 1'b1;  // locally generated PTP stream

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_XFER = 2'd2,
    ST_DROP = 2'd3
  } state_e;

  // True when the word closes a packet
  function automatic logic is_last(input logic [WORD_W-1:0] word);
    return word[WORD_W-1 -: 2] == WT_LAST;
  endfunction

  // Packet-level round robin: when both ports hold a packet the port named
  // by prio wins, otherwise whichever port is eligible.
  function automatic logic rr_grant(input logic [NUM_PORTS-1:0] elig,
                                    input logic                 prio);
    if (elig[PORT_A] && elig[PORT_B]) begin
      return prio;
    end
    return elig[PORT_B];
  endfunction

endpackage

// File: rtl/ptp_tx_mux_pkt_sync_fifo.sv
// pkt_sync_fifo: single-clock FIFO on an inferred RAM with a registered,
// look-ahead read. The head word is always presented on rd_data one cycle
// after any pointer change, so rd_en acts as a "pop" of the visible word.
// A write that lands on the next head location is bypassed straight into
// the output register to hide the RAM read-during-write latency.
module pkt_sync_fifo #(
  parameter  int WIDTH = 134,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      usedw,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] head_q;
  logic             wr_ok, rd_ok, bypass;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign rd_ok = rd_en && !empty;
  // A full FIFO still accepts a word when the same cycle frees a slot
  assign wr_ok = wr_en && (!full || rd_ok);

  // Next pointer and occupancy; simultaneous push and pop keep the count
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_ok && !rd_ok) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!wr_ok && rd_ok) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  assign bypass = wr_ok && (wr_ptr_q == rd_ptr_d);

  // RAM write port
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_data;
  end

  // Registered read of the next head location, with write bypass
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
    end else begin
      head_q <= bypass ? wr_data : mem[rd_ptr_d];
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data = head_q;
  assign usedw   = count_q;

endmodule

// File: rtl/ptp_tx_mux.sv
// ptp_tx_mux: merges the forwarded parser stream (port A) and the local PTP
// stream (port B) into one store-and-forward stream towards the switch core.
// Each port buffers words in a data FIFO and per-packet good/drop flags in a
// status FIFO; a packet is only considered once its flag is stored.
// Build option: define PTP_STRICT_PRIO_EN to give port B absolute priority
// instead of packet-level round robin.
module ptp_tx_mux
  import ptp_tx_mux_pkg::*;
#(
  parameter int DATA_DEPTH  = 256,
  parameter int VALID_DEPTH = 16,
  parameter int ALF_MARGIN  = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              parser2mux_data_wr,
  input  logic [WORD_W-1:0] parser2mux_data,
  input  logic              parser2mux_data_valid,
  input  logic              parser2mux_data_valid_wr,
  output logic              mux2parser_data_alf,
  input  logic              ptp2mux_data_wr,
  input  logic [WORD_W-1:0] ptp2mux_data,
  input  logic              ptp2mux_data_valid,
  input  logic              ptp2mux_data_valid_wr,
  output logic              mux2ptp_data_alf,
  output logic              mux2sw_data_wr,
  output logic [WORD_W-1:0] mux2sw_data,
  output logic              mux2sw_data_valid,
  output logic              mux2sw_data_valid_wr,
  input  logic              sw2mux_data_alf
);

  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int SAW = $clog2(VALID_DEPTH);

  // Per-port views of the two input streams, indexed by PORT_A / PORT_B
  logic [NUM_PORTS-1:0] in_data_wr, in_valid, in_valid_wr;
  logic [WORD_W-1:0]    in_data [NUM_PORTS];

  assign in_data_wr      = {ptp2mux_data_wr, parser2mux_data_wr};
  assign in_valid        = {ptp2mux_data_valid, parser2mux_data_valid};
  assign in_valid_wr     = {ptp2mux_data_valid_wr, parser2mux_data_valid_wr};
  assign in_data[PORT_A] = parser2mux_data;
  assign in_data[PORT_B] = ptp2mux_data;

  logic [WORD_W-1:0]    head_data  [NUM_PORTS];
  logic [DAW:0]         data_usedw [NUM_PORTS];
  logic [SAW:0]         stat_usedw [NUM_PORTS];
  logic [NUM_PORTS-1:0] data_full, data_empty, data_pop;
  logic [NUM_PORTS-1:0] stat_full, stat_empty, stat_head, stat_pop;
  logic [NUM_PORTS-1:0] alf_d, alf_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      pkt_sync_fifo #(
        .WIDTH(WORD_W),
        .DEPTH(DATA_DEPTH)
      ) u_data_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (in_data_wr[gi]),
        .wr_data(in_data[gi]),
        .rd_en  (data_pop[gi]),
        .rd_data(head_data[gi]),
        .usedw  (data_usedw[gi]),
        .full   (data_full[gi]),
        .empty  (data_empty[gi])
      );

      pkt_sync_fifo #(
        .WIDTH(1),
        .DEPTH(VALID_DEPTH)
      ) u_stat_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (in_valid_wr[gi]),
        .wr_data(in_valid[gi]),
        .rd_en  (stat_pop[gi]),
        .rd_data(stat_head[gi]),
        .usedw  (stat_usedw[gi]),
        .full   (stat_full[gi]),
        .empty  (stat_empty[gi])
      );

      // Back-pressure when data space drops under the margin or the status
      // FIFO can take at most one more flag
      assign alf_d[gi] = data_full[gi] || stat_full[gi] ||
                         ((DATA_DEPTH - int'(data_usedw[gi])) < ALF_MARGIN) ||
                         ((VALID_DEPTH - int'(stat_usedw[gi])) <= 1);
    end
  endgenerate

  // Registered almost-full flags towards both producers
  always_ff @(posedge clk) begin
    if (rst) alf_q <= '0;
    else     alf_q <= alf_d;
  end

  assign mux2parser_data_alf = alf_q[PORT_A];
  assign mux2ptp_data_alf    = alf_q[PORT_B];

  // Arbitration
  state_e               state_q, state_d;
  logic                 sel_q, sel_d;      // port being transferred/dropped
  logic                 prio_q, prio_d;    // port that wins a tie
  logic                 grant;
  logic [NUM_PORTS-1:0] eligible;
  logic [WORD_W-1:0]    cur_word;

  logic              out_wr_q, out_wr_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_vwr_q, out_vwr_d;

  assign eligible = ~stat_empty;
  assign cur_word = head_data[sel_q];

  // Port selection for the next packet
  always_comb begin
`ifdef PTP_STRICT_PRIO_EN
    grant = eligible[PORT_B] ? PORT_B : PORT_A;
`else
    grant = rr_grant(eligible, prio_q);
`endif
  end

  // Next-state, FIFO pops and next output values
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    prio_d      = prio_q;
    data_pop    = '0;
    stat_pop    = '0;
    out_wr_d    = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_vwr_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if ((|eligible) && !sw2mux_data_alf) state_d = ST_ARB;
      end

      ST_ARB: begin
        if (|eligible) begin
          sel_d           = grant;
          prio_d          = ~grant;
          stat_pop[grant] = 1'b1;
          state_d         = stat_head[grant] ? ST_XFER : ST_DROP;
        end else begin
          state_d = ST_IDLE;
        end
      end

      // Forward one word per cycle regardless of downstream almost-full
      ST_XFER: begin
        if (!data_empty[sel_q]) begin
          data_pop[sel_q] = 1'b1;
          out_wr_d        = 1'b1;
          out_data_d      = cur_word;
          if (is_last(cur_word)) begin
            out_vwr_d   = 1'b1;
            out_valid_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end

      // Discard a packet flagged bad, word by word
      ST_DROP: begin
        if (!data_empty[sel_q]) begin
          data_pop[sel_q] = 1'b1;
          if (is_last(cur_word)) state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, selection and registered output stream
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= PORT_A;
      prio_q      <= PORT_A;
      out_wr_q    <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_vwr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      prio_q      <= prio_d;
      out_wr_q    <= out_wr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_vwr_q   <= out_vwr_d;
    end
  end

  assign mux2sw_data_wr       = out_wr_q;
  assign mux2sw_data          = out_data_q;
  assign mux2sw_data_valid    = out_valid_q;
  assign mux2sw_data_valid_wr = out_vwr_q;

endmodule

// File: tb/tb_ptp_tx_mux.sv
// Directed bench for ptp_tx_mux: packets are built from a tag and word index,
// the merged stream is captured on the falling edge and compared word by
// word against hand-built expected packets.
module tb_ptp_tx_mux;

  localparam int W = 134;
  localparam logic [1:0] T_FIRST = 2'b01;
  localparam logic [1:0] T_MID   = 2'b11;
  localparam logic [1:0] T_LAST  = 2'b10;

  logic         clk = 1'b0;
  logic         rst;
  logic         parser2mux_data_wr, parser2mux_data_valid, parser2mux_data_valid_wr;
  logic [W-1:0] parser2mux_data;
  logic         mux2parser_data_alf;
  logic         ptp2mux_data_wr, ptp2mux_data_valid, ptp2mux_data_valid_wr;
  logic [W-1:0] ptp2mux_data;
  logic         mux2ptp_data_alf;
  logic         mux2sw_data_wr, mux2sw_data_valid, mux2sw_data_valid_wr;
  logic [W-1:0] mux2sw_data;
  logic         sw2mux_data_alf;

  always #5 clk = ~clk;

  ptp_tx_mux dut (
    .clk                     (clk),
    .rst                     (rst),
    .parser2mux_data_wr      (parser2mux_data_wr),
    .parser2mux_data         (parser2mux_data),
    .parser2mux_data_valid   (parser2mux_data_valid),
    .parser2mux_data_valid_wr(parser2mux_data_valid_wr),
    .mux2parser_data_alf     (mux2parser_data_alf),
    .ptp2mux_data_wr         (ptp2mux_data_wr),
    .ptp2mux_data            (ptp2mux_data),
    .ptp2mux_data_valid      (ptp2mux_data_valid),
    .ptp2mux_data_valid_wr   (ptp2mux_data_valid_wr),
    .mux2ptp_data_alf        (mux2ptp_data_alf),
    .mux2sw_data_wr          (mux2sw_data_wr),
    .mux2sw_data             (mux2sw_data),
    .mux2sw_data_valid       (mux2sw_data_valid),
    .mux2sw_data_valid_wr    (mux2sw_data_valid_wr),
    .sw2mux_data_alf         (sw2mux_data_alf)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] word;
    logic         vwr;
    logic         valid;
    int           cyc;
  } rec_t;

  rec_t out_q[$];

  always @(negedge clk) begin : mon
    rec_t r;
    if (mux2sw_data_wr || mux2sw_data_valid_wr) begin
      r.word  = mux2sw_data;
      r.vwr   = mux2sw_data_valid_wr;
      r.valid = mux2sw_data_valid;
      r.cyc   = cyc;
      out_q.push_back(r);
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int wr_edge  = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] make_word(input logic [1:0] wt, input logic [7:0] tag,
                                              input logic [7:0] idx);
    return {wt, 116'd0, tag, idx};
  endfunction

  function automatic logic [1:0] wt_of(input int i, input int nw);
    if (i == 0) return T_FIRST;
    if (i == nw - 1) return T_LAST;
    return T_MID;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    parser2mux_data_wr       = 1'b0;
    parser2mux_data          = '0;
    parser2mux_data_valid    = 1'b0;
    parser2mux_data_valid_wr = 1'b0;
    ptp2mux_data_wr          = 1'b0;
    ptp2mux_data             = '0;
    ptp2mux_data_valid       = 1'b0;
    ptp2mux_data_valid_wr    = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Drive one packet on A and/or B in lockstep; status flag with last word
  task automatic send_pkts(input bit use_a, input bit use_b, input int nw,
                           input logic [7:0] tag_a, input logic [7:0] tag_b,
                           input bit good_a, input bit good_b);
    for (int i = 0; i < nw; i++) begin
      parser2mux_data_wr       = use_a;
      parser2mux_data          = make_word(wt_of(i, nw), tag_a, 8'(i));
      parser2mux_data_valid_wr = use_a && (i == nw - 1);
      parser2mux_data_valid    = good_a && (i == nw - 1);
      ptp2mux_data_wr          = use_b;
      ptp2mux_data             = make_word(wt_of(i, nw), tag_b, 8'(i));
      ptp2mux_data_valid_wr    = use_b && (i == nw - 1);
      ptp2mux_data_valid       = good_b && (i == nw - 1);
      if (i == nw - 1) wr_edge = cyc + 1;
      tick();
    end
    idle_inputs();
  endtask

  task automatic wait_words(input string tag, input int n, input int budget);
    int k = 0;
    while (out_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_count"}, W'(out_q.size()), W'(n));
  endtask

  // Compare one captured packet against its expected words
  task automatic check_pkt(input string tag, input int base, input int nw, input logic [7:0] ptag);
    if (out_q.size() < base + nw) begin
      chk({tag, "_size"}, W'(out_q.size()), W'(base + nw));
      return;
    end
    for (int i = 0; i < nw; i++) begin
      chk($sformatf("%s_w%0d", tag, i), out_q[base+i].word, make_word(wt_of(i, nw), ptag, 8'(i)));
      chk($sformatf("%s_vwr%0d", tag, i), W'(out_q[base+i].vwr), W'(i == nw - 1));
      chk($sformatf("%s_gap%0d", tag, i), W'(out_q[base+i].cyc - out_q[base].cyc), W'(i));
      if (i == nw - 1) chk($sformatf("%s_valid", tag), W'(out_q[base+i].valid), W'(1));
    end
    $display("pkt %s: tag %0h, %0d words at cycle %0d", tag, ptag, nw, out_q[base].cyc);
  endtask

  initial begin
    int lat, pre, nvwr, k;
    idle_inputs();
    sw2mux_data_alf = 1'b0;
    rst = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_wr",    W'(mux2sw_data_wr), W'(0));
    chk("rst_vwr",   W'(mux2sw_data_valid_wr), W'(0));
    chk("rst_valid", W'(mux2sw_data_valid), W'(0));
    chk("rst_data",  mux2sw_data, W'(0));
    chk("rst_alf_a", W'(mux2parser_data_alf), W'(0));
    chk("rst_alf_b", W'(mux2ptp_data_alf), W'(0));
    rst = 1'b0;
    tick();

    // Single good 4-word packet on A, latency from status write
    out_q.delete();
    send_pkts(1, 0, 4, 8'hA1, 8'h00, 1, 0);
    wait_words("t1", 4, 20);
    check_pkt("t1", 0, 4, 8'hA1);
    lat = (out_q.size() > 0) ? out_q[0].cyc - wr_edge : -1;
    chk("t1_latency", W'(lat), W'(3));

    // Four packets per port stored together -> A,B,A,B,...
    apply_reset();
    out_q.delete();
    sw2mux_data_alf = 1'b1;
    for (int p = 0; p < 4; p++) send_pkts(1, 1, 3, 8'(8'hA0 + p), 8'(8'hB0 + p), 1, 1);
    repeat (10) tick();
    chk("t2_held", W'(out_q.size()), W'(0));
    sw2mux_data_alf = 1'b0;
    wait_words("t2", 24, 120);
    for (int p = 0; p < 8; p++) begin
      check_pkt($sformatf("t2_p%0d", p), 3 * p, 3,
                (p % 2 == 0) ? 8'(8'hA0 + p / 2) : 8'(8'hB0 + p / 2));
    end

    // Bad packet on A is dropped, good packet on B follows
    out_q.delete();
    send_pkts(1, 0, 4, 8'hD0, 8'h00, 0, 0);
    send_pkts(0, 1, 4, 8'h00, 8'hD1, 0, 1);
    wait_words("t3", 4, 40);
    repeat (10) tick();
    chk("t3_exact", W'(out_q.size()), W'(4));
    check_pkt("t3", 0, 4, 8'hD1);

    // Downstream almost-full holds the start but not a running packet
    out_q.delete();
    sw2mux_data_alf = 1'b1;
    send_pkts(1, 0, 6, 8'hE0, 8'h00, 1, 0);
    repeat (10) tick();
    chk("t4_held", W'(out_q.size()), W'(0));
    sw2mux_data_alf = 1'b0;
    repeat (5) tick();
    chk("t4_started", W'(out_q.size() > 0 && out_q.size() < 6), W'(1));
    sw2mux_data_alf = 1'b1;
    wait_words("t4", 6, 30);
    check_pkt("t4", 0, 6, 8'hE0);
    sw2mux_data_alf = 1'b0;
    repeat (5) tick();

    // Almost-full threshold on A: 157 words stored
    apply_reset();
    sw2mux_data_alf = 1'b1;
    for (int i = 0; i < 157; i++) begin
      parser2mux_data_wr = 1'b1;
      parser2mux_data    = make_word(T_MID, 8'h55, 8'(i));
      tick();
    end
    idle_inputs();
    chk("t5_alf_at_157", W'(mux2parser_data_alf), W'(0));
    tick();
    chk("t5_alf_after", W'(mux2parser_data_alf), W'(1));
    chk("t5_alf_b", W'(mux2ptp_data_alf), W'(0));
    apply_reset();
    chk("t5_alf_rst", W'(mux2parser_data_alf), W'(0));
    sw2mux_data_alf = 1'b0;

    // Reset in the middle of a 6-word transfer
    out_q.delete();
    send_pkts(1, 0, 6, 8'hC6, 8'h00, 1, 0);
    k = 0;
    while (!(mux2sw_data_wr && mux2sw_data[7:0] == 8'd1) && k < 20) begin
      tick();
      k++;
    end
    chk("t6_word2_seen", W'(k < 20), W'(1));
    rst = 1'b1;
    tick();
    chk("t6_rst_wr",    W'(mux2sw_data_wr), W'(0));
    chk("t6_rst_vwr",   W'(mux2sw_data_valid_wr), W'(0));
    chk("t6_rst_data",  mux2sw_data, W'(0));
    chk("t6_rst_alf_a", W'(mux2parser_data_alf), W'(0));
    rst = 1'b0;
    pre = out_q.size();
    repeat (20) tick();
    chk("t6_quiet", W'(out_q.size()), W'(pre));
    nvwr = 0;
    foreach (out_q[i]) if (out_q[i].vwr) nvwr++;
    chk("t6_no_vwr", W'(nvwr), W'(0));
    send_pkts(1, 0, 3, 8'hC7, 8'h00, 1, 0);
    wait_words("t6", pre + 3, 30);
    check_pkt("t6", pre, 3, 8'hC7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
